// File: rtl/aud_pwm_seq.sv
// aud_pwm_seq: sample sequencer for the audio PWM datapath.
// Buffers duty samples in a FIFO and releases one every rate_div_i+1 cycles
// to the modulator, with start/stop control, priming, underrun and low-level flag.
// Ports:
//   pclk_i, presetn_i          clock, async active-low reset
//   start_i, stop_i            playback control pulses (stop has priority)
//   rate_div_i                 sample period minus 1, in pclk cycles
//   wr_valid_i, wr_data_i      sample push; wr_ready_o = FIFO not full
//   underrun_clr_i             clears sticky underrun_o
//   pwm_duty_o, pwm_load_o     duty value and its one-cycle update strobe
//   pwm_en_o, busy_o           modulator enable (PLAY), sequencer not idle
//   level_o, underrun_o        FIFO occupancy, sticky underrun flag
//   irq_low_o                  level_o <= LOW_WM while playing
module aud_pwm_seq #(
   parameter int unsigned SAMPLE_W  = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned PRIME_LVL = 4,
   parameter int unsigned LOW_WM    = 4
) (
   input  logic                      pclk_i,
   input  logic                      presetn_i,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic [15:0]               rate_div_i,
   input  logic                      wr_valid_i,
   input  logic [SAMPLE_W-1:0]       wr_data_i,
   output logic                      wr_ready_o,
   input  logic                      underrun_clr_i,
   output logic [SAMPLE_W-1:0]       pwm_duty_o,
   output logic                      pwm_load_o,
   output logic                      pwm_en_o,
   output logic                      busy_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      underrun_o,
   output logic                      irq_low_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

   state_t               state_q, state_nxt;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_nxt;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_nxt;
   logic [LVL_W-1:0]     level_nxt;
   logic [15:0]          cnt_q, cnt_nxt;
   logic [SAMPLE_W-1:0]  duty_nxt;
   logic                 load_nxt;
   logic                 underrun_nxt;
   logic                 ready_nxt;
   logic                 en_nxt;
   logic                 busy_nxt;
   logic                 irq_nxt;
   logic                 push;
   logic                 pop;
   logic [SAMPLE_W-1:0]  mem [DEPTH];

   // Sample storage; written only by accepted pushes
   always_ff @(posedge pclk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   // Sequencer state, FIFO bookkeeping and registered outputs
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_o    <= '0;
         cnt_q      <= '0;
         pwm_duty_o <= MID;
         pwm_load_o <= 1'b0;
         underrun_o <= 1'b0;
         wr_ready_o <= 1'b1;
         pwm_en_o   <= 1'b0;
         busy_o     <= 1'b0;
         irq_low_o  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         rd_ptr_q   <= rd_ptr_nxt;
         wr_ptr_q   <= wr_ptr_nxt;
         level_o    <= level_nxt;
         cnt_q      <= cnt_nxt;
         pwm_duty_o <= duty_nxt;
         pwm_load_o <= load_nxt;
         underrun_o <= underrun_nxt;
         wr_ready_o <= ready_nxt;
         pwm_en_o   <= en_nxt;
         busy_o     <= busy_nxt;
         irq_low_o  <= irq_nxt;
      end
   end

   // Next-state, FIFO and output decode
   always_comb begin
      state_nxt    = state_q;
      rd_ptr_nxt   = rd_ptr_q;
      wr_ptr_nxt   = wr_ptr_q;
      level_nxt    = level_o;
      cnt_nxt      = cnt_q;
      duty_nxt     = pwm_duty_o;
      load_nxt     = 1'b0;
      underrun_nxt = underrun_o & ~underrun_clr_i;
      push         = wr_valid_i & wr_ready_o;
      pop          = 1'b0;

      if (stop_i) begin
         // Flush overrides any same-cycle push, pop or start
         state_nxt  = IDLE;
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         level_nxt  = '0;
         cnt_nxt    = '0;
         duty_nxt   = MID;
         push       = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_nxt = PRIME;
               end
            end
            PRIME: begin
               if (level_o >= LVL_W'(PRIME_LVL)) begin
                  state_nxt = PLAY;
                  pop       = 1'b1;
                  load_nxt  = 1'b1;
                  cnt_nxt   = rate_div_i;
               end
            end
            PLAY: begin
               if (cnt_q != '0) begin
                  cnt_nxt = cnt_q - 16'd1;
               end else begin
                  cnt_nxt  = rate_div_i;
                  load_nxt = 1'b1;
                  // Emptiness is judged before this cycle's push: no bypass
                  if (level_o != '0) begin
                     pop = 1'b1;
                  end else begin
                     duty_nxt     = MID;
                     underrun_nxt = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase

         if (pop) begin
            duty_nxt   = mem[rd_ptr_q];
            rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
         end
         if (push) begin
            wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
         end
         level_nxt = level_o + LVL_W'(push) - LVL_W'(pop);
      end

      ready_nxt = (level_nxt != LVL_W'(DEPTH));
      en_nxt    = (state_nxt == PLAY);
      busy_nxt  = (state_nxt != IDLE);
      irq_nxt   = en_nxt & (level_nxt <= LVL_W'(LOW_WM));
   end

endmodule

// File: tb/tb_aud_pwm_seq.sv
// Self-checking bench for aud_pwm_seq: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_aud_pwm_seq;

   logic        pclk_i = 1'b0;
   logic        presetn_i = 1'b0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic [15:0] rate_div_i = 16'd0;
   logic        wr_valid_i = 1'b0;
   logic [7:0]  wr_data_i = 8'h00;
   logic        wr_ready_o;
   logic        underrun_clr_i = 1'b0;
   logic [7:0]  pwm_duty_o;
   logic        pwm_load_o;
   logic        pwm_en_o;
   logic        busy_o;
   logic [4:0]  level_o;
   logic        underrun_o;
   logic        irq_low_o;

   aud_pwm_seq dut (
      .pclk_i        (pclk_i),
      .presetn_i     (presetn_i),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .rate_div_i    (rate_div_i),
      .wr_valid_i    (wr_valid_i),
      .wr_data_i     (wr_data_i),
      .wr_ready_o    (wr_ready_o),
      .underrun_clr_i(underrun_clr_i),
      .pwm_duty_o    (pwm_duty_o),
      .pwm_load_o    (pwm_load_o),
      .pwm_en_o      (pwm_en_o),
      .busy_o        (busy_o),
      .level_o       (level_o),
      .underrun_o    (underrun_o),
      .irq_low_o     (irq_low_o)
   );

   always #5 pclk_i = ~pclk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // {ready, duty, load, en, busy, level, underrun, irq}
   function automatic logic [18:0] dut_out();
      return {wr_ready_o, pwm_duty_o, pwm_load_o, pwm_en_o, busy_o,
              level_o, underrun_o, irq_low_o};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, pass the edge, settle 1 time unit after it
   task automatic cyc(input bit s, input bit p, input bit w, input logic [7:0] d,
                      input bit c, input logic [15:0] r);
      start_i = s; stop_i = p; wr_valid_i = w; wr_data_i = d;
      underrun_clr_i = c; rate_div_i = r;
      @(posedge pclk_i);
      #1;
      start_i = 1'b0; stop_i = 1'b0; wr_valid_i = 1'b0; underrun_clr_i = 1'b0;
   endtask

   task automatic do_reset();
      #1 presetn_i = 1'b0;
      #12 presetn_i = 1'b1;
      @(posedge pclk_i);
      #1;
   endtask

   // ---------------- behavioural reference ----------------
   logic [7:0] mq[$];
   int         m_mode;   // 0 idle, 1 waiting for prime level, 2 playing
   int         m_wait;   // cycles left before the next sample is due
   logic [7:0] m_duty;
   bit         m_load;
   bit         m_unf;

   task automatic model_reset();
      mq.delete(); m_mode = 0; m_wait = 0; m_duty = 8'h80; m_load = 0; m_unf = 0;
   endtask

   task automatic model_edge(input bit s, input bit p, input bit w, input logic [7:0] d,
                             input bit c, input logic [15:0] r);
      bit accept = w && (mq.size() < 16);
      bit uflow = 0;
      m_load = 0;
      if (p) begin
         mq.delete(); m_mode = 0; m_duty = 8'h80;
      end else begin
         if (m_mode == 0) begin
            if (s) m_mode = 1;
         end else if (m_mode == 1) begin
            if (mq.size() >= 4) begin
               m_mode = 2; m_duty = mq.pop_front(); m_load = 1; m_wait = int'(r);
            end
         end else begin
            if (m_wait > 0) m_wait--;
            else begin
               m_wait = int'(r); m_load = 1;
               if (mq.size() > 0) m_duty = mq.pop_front();
               else begin m_duty = 8'h80; uflow = 1; end
            end
         end
         if (accept) mq.push_back(d);
      end
      m_unf = uflow ? 1'b1 : (c ? 1'b0 : m_unf);
   endtask

   function automatic logic [18:0] model_out();
      bit play = (m_mode == 2);
      return {mq.size() < 16, m_duty, m_load, play, m_mode != 0,
              5'(mq.size()), m_unf, play && (mq.size() <= 4)};
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          s, p, w;
      logic [7:0]  d;
      bit          c;
      logic [15:0] r;
      logic [18:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit s, input bit p, input bit w, input logic [7:0] d,
                      input bit c, input bit rdy, input logic [7:0] du, input bit ld,
                      input bit en, input bit bz, input int lvl, input bit unf, input bit irq);
      vec_t v;
      v.s = s; v.p = p; v.w = w; v.d = d; v.c = c; v.r = 16'd3;
      v.exp = {rdy, du, ld, en, bz, 5'(lvl), unf, irq};
      tbl.push_back(v);
   endtask

   logic [7:0] fs[16];

   initial begin
      // Normal playback at rate_div 3, underrun, sticky clear, stop, start+stop
      add(0,0,1,8'h10,0, 1,8'h80,0,0,0,1,0,0);
      add(0,0,1,8'h20,0, 1,8'h80,0,0,0,2,0,0);
      add(0,0,1,8'h30,0, 1,8'h80,0,0,0,3,0,0);
      add(0,0,1,8'h40,0, 1,8'h80,0,0,0,4,0,0);
      add(1,0,0,8'h00,0, 1,8'h80,0,0,1,4,0,0);
      add(0,0,0,8'h00,0, 1,8'h10,1,1,1,3,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, 1,8'h10,0,1,1,3,0,1);
      add(0,0,0,8'h00,0, 1,8'h20,1,1,1,2,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, 1,8'h20,0,1,1,2,0,1);
      add(0,0,0,8'h00,0, 1,8'h30,1,1,1,1,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, 1,8'h30,0,1,1,1,0,1);
      add(0,0,0,8'h00,0, 1,8'h40,1,1,1,0,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, 1,8'h40,0,1,1,0,0,1);
      add(0,0,0,8'h00,0, 1,8'h80,1,1,1,0,1,1);
      for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, 1,8'h80,0,1,1,0,1,1);
      add(0,0,0,8'h00,1, 1,8'h80,1,1,1,0,1,1);   // clr loses to new underrun
      add(0,0,0,8'h00,1, 1,8'h80,0,1,1,0,0,1);   // clr alone clears
      add(0,1,1,8'h55,0, 1,8'h80,0,0,0,0,0,0);   // stop, push discarded
      add(1,1,0,8'h00,0, 1,8'h80,0,0,0,0,0,0);   // start+stop stays idle

      do_reset();
      chk("reset_state", 32'(dut_out()), 32'({1'b1, 8'h80, 10'd0}));
      foreach (tbl[i]) begin
         cyc(tbl[i].s, tbl[i].p, tbl[i].w, tbl[i].d, tbl[i].c, tbl[i].r);
         chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
      end

      // Priming: stays in PRIME until level reaches 4
      do_reset();
      cyc(0,0,1,8'hA1,0,16'd2);
      cyc(0,0,1,8'hA2,0,16'd2);
      cyc(1,0,0,8'h00,0,16'd2);
      chk("prime_busy", 32'({busy_o, pwm_en_o}), 32'b10);
      cyc(0,0,0,8'h00,0,16'd2);
      chk("prime_hold", 32'({busy_o, pwm_en_o, level_o}), 32'({2'b10, 5'd2}));
      cyc(0,0,1,8'hA3,0,16'd2);
      cyc(0,0,1,8'hA4,0,16'd2);
      chk("prime_lvl4", 32'({busy_o, pwm_en_o, pwm_load_o, level_o}), 32'({3'b100, 5'd4}));
      cyc(0,0,0,8'h00,0,16'd2);
      chk("prime_first_load", 32'({pwm_en_o, pwm_load_o, pwm_duty_o, level_o}),
          32'({2'b11, 8'hA1, 5'd3}));
      cyc(0,0,0,8'h00,0,16'd2);
      // Asynchronous reset mid-playback
      #2 presetn_i = 1'b0;
      #1;
      chk("async_reset", 32'(dut_out()), 32'({1'b1, 8'h80, 10'd0}));
      #6 presetn_i = 1'b1;
      @(posedge pclk_i); #1;

      // Full boundary then back-to-back playback at rate_div 0
      for (int i = 0; i < 16; i++) begin
         fs[i] = 8'(i * 13 + 7);
         cyc(0,0,1,fs[i],0,16'd0);
      end
      chk("full_ready", 32'({wr_ready_o, level_o}), 32'({1'b0, 5'd16}));
      cyc(0,0,1,8'hEE,0,16'd0);
      chk("full_drop", 32'({wr_ready_o, level_o}), 32'({1'b0, 5'd16}));
      cyc(1,0,0,8'h00,0,16'd0);
      chk("full_prime", 32'({busy_o, pwm_load_o, level_o}), 32'({2'b10, 5'd16}));
      for (int i = 0; i < 16; i++) begin
         cyc(0,0,0,8'h00,0,16'd0);
         chk($sformatf("full_load%0d", i), 32'({pwm_load_o, pwm_duty_o, level_o, underrun_o}),
             32'({1'b1, fs[i], 5'(15 - i), 1'b0}));
      end
      cyc(0,0,0,8'h00,0,16'd0);
      chk("full_underrun", 32'({pwm_load_o, pwm_duty_o, underrun_o}), 32'({1'b1, 8'h80, 1'b1}));

      // Stop mid-PLAY with level 5, alongside start and a push
      do_reset();
      for (int i = 0; i < 6; i++) cyc(0,0,1,8'(8'h60 + i),0,16'd2);
      cyc(1,0,0,8'h00,0,16'd2);
      cyc(0,0,0,8'h00,0,16'd2);
      chk("stop_pre", 32'({pwm_en_o, level_o}), 32'({1'b1, 5'd5}));
      cyc(1,1,1,8'h99,0,16'd2);
      chk("stop_post", 32'(dut_out()), 32'({1'b1, 8'h80, 10'd0}));

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      begin
         logic [15:0] r = 16'd1;
         for (int n = 0; n < 4000; n++) begin
            bit s, p, w, c;
            logic [7:0] d;
            s = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 9) < 4);
            c = ($urandom_range(0, 29) == 0);
            d = 8'($urandom);
            if ($urandom_range(0, 49) == 0) r = 16'($urandom_range(0, 4));
            cyc(s, p, w, d, c, r);
            model_edge(s, p, w, d, c, r);
            chk($sformatf("rand%0d", n), 32'(dut_out()), 32'(model_out()));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
